fp_addsub_sched: RTL and testbench

- Round-robin scheduler that shares one fp add/sub datapath instance among P_NREQ independent requesters.
- Per cycle, accepts at most one operation over a valid/ready handshake and registers its operands onto the datapath inputs.
- Tracks each in-flight operation by requester tag through a fixed-latency pipeline and returns the result and status to the originating requester.
- Sits between the requester blocks and the fp add/sub datapath; the datapath has no valid signal of its own.

---
 rtl/fp_addsub_sched_if.sv | 34 +++
 rtl/fp_addsub_sched.sv | 143 ++++++++++++++
 tb/tb_fp_addsub_sched.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fp_addsub_sched_if.sv
// Bundle of requester, datapath and response signals around the shared fp add/sub scheduler.
// The scheduler uses the slave modport; requesters and the datapath together form the master side.
interface fp_addsub_sched_if #(
    parameter int P_WORD = 16,
    parameter int P_NREQ = 4
);
    logic                     cfg_en;
    logic [P_NREQ-1:0]        req_vld;
    logic [P_NREQ-1:0]        req_rdy;
    logic [P_NREQ*P_WORD-1:0] req_a;
    logic [P_NREQ*P_WORD-1:0] req_b;
    logic [P_NREQ-1:0]        req_op;
    logic [P_NREQ*3-1:0]      req_rnd;
    logic [P_WORD-1:0]        dp_a;
    logic [P_WORD-1:0]        dp_b;
    logic                     dp_op;
    logic [2:0]               dp_rnd;
    logic [P_WORD-1:0]        dp_z;
    logic [7:0]               dp_status;
    logic [P_NREQ-1:0]        rsp_vld;
    logic [P_WORD-1:0]        rsp_z;
    logic [7:0]               rsp_status;
    logic                     idle;

    modport master (
        output cfg_en, req_vld, req_a, req_b, req_op, req_rnd, dp_z, dp_status,
        input  req_rdy, dp_a, dp_b, dp_op, dp_rnd, rsp_vld, rsp_z, rsp_status, idle
    );

    modport slave (
        input  cfg_en, req_vld, req_a, req_b, req_op, req_rnd, dp_z, dp_status,
        output req_rdy, dp_a, dp_b, dp_op, dp_rnd, rsp_vld, rsp_z, rsp_status, idle
    );
endinterface

// File: rtl/fp_addsub_sched.sv
// Round-robin front end sharing one fixed-latency fp add/sub datapath among P_NREQ requesters.
// A requester tag travels beside the datapath so each result returns to its originator.
module fp_addsub_sched #(
    parameter int P_EXP  = 5,
    parameter int P_FRAC = 10,
    parameter int P_BIAS = 15,
    parameter int P_WORD = 1 + P_FRAC + P_EXP,
    parameter int P_NREQ = 4,
    parameter int P_LAT  = 2,
    parameter int P_TW   = $clog2(P_NREQ)
) (
    input  logic             clk,
    input  logic             rst,
    fp_addsub_sched_if.slave bus
);

    if (P_NREQ < 2 || P_NREQ > 8 || P_LAT < 0 || P_LAT > 8 || P_BIAS < 0) begin : g_param_check
        $error("fp_addsub_sched: parameter out of supported range");
    end

    logic [P_WORD-1:0] req_a_arr   [P_NREQ];
    logic [P_WORD-1:0] req_b_arr   [P_NREQ];
    logic [2:0]        req_rnd_arr [P_NREQ];

    for (genvar gi = 0; gi < P_NREQ; gi++) begin : g_unpack
        assign req_a_arr[gi]   = bus.req_a[gi*P_WORD +: P_WORD];
        assign req_b_arr[gi]   = bus.req_b[gi*P_WORD +: P_WORD];
        assign req_rnd_arr[gi] = bus.req_rnd[gi*3 +: 3];
    end

    logic [P_TW-1:0]   ptr_q, ptr_d;
    logic [P_WORD-1:0] dp_a_q, dp_a_d;
    logic [P_WORD-1:0] dp_b_q, dp_b_d;
    logic              dp_op_q, dp_op_d;
    logic [2:0]        dp_rnd_q, dp_rnd_d;
    logic              tag_vld_q [P_LAT+1];
    logic [P_TW-1:0]   tag_q     [P_LAT+1];
    logic [P_NREQ-1:0] rsp_vld_q, rsp_vld_d;
    logic [P_WORD-1:0] rsp_z_q, rsp_z_d;
    logic [7:0]        rsp_status_q, rsp_status_d;

    logic [P_TW-1:0]   gnt_idx;
    logic              gnt_found;
    logic [P_NREQ-1:0] gnt;
    logic              accept;
    logic              inflight;
    int                arb_cand;

    // Circular first-set search starting just after the last granted requester.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = ptr_q;
        arb_cand  = 0;
        for (int k = 1; k <= P_NREQ; k++) begin
            arb_cand = int'(ptr_q) + k;
            if (arb_cand >= P_NREQ) begin
                arb_cand = arb_cand - P_NREQ;
            end
            if (!gnt_found && bus.req_vld[P_TW'(arb_cand)]) begin
                gnt_found = 1'b1;
                gnt_idx   = P_TW'(arb_cand);
            end
        end
        gnt          = '0;
        gnt[gnt_idx] = gnt_found;
    end

    assign bus.req_rdy = gnt & {P_NREQ{bus.cfg_en & ~rst}};
    assign accept      = |(bus.req_vld & bus.req_rdy);

    always_comb begin
        ptr_d        = ptr_q;
        dp_a_d       = dp_a_q;
        dp_b_d       = dp_b_q;
        dp_op_d      = dp_op_q;
        dp_rnd_d     = dp_rnd_q;
        rsp_vld_d    = '0;
        rsp_z_d      = rsp_z_q;
        rsp_status_d = rsp_status_q;
        // Operand registers only move on an accept so the datapath inputs stay quiet otherwise.
        if (accept) begin
            ptr_d    = gnt_idx;
            dp_a_d   = req_a_arr[gnt_idx];
            dp_b_d   = req_b_arr[gnt_idx];
            dp_op_d  = bus.req_op[gnt_idx];
            dp_rnd_d = req_rnd_arr[gnt_idx];
        end
        if (tag_vld_q[P_LAT]) begin
            rsp_vld_d[tag_q[P_LAT]] = 1'b1;
            rsp_z_d                 = bus.dp_z;
            rsp_status_d            = bus.dp_status;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q        <= P_TW'(P_NREQ - 1);
            dp_a_q       <= '0;
            dp_b_q       <= '0;
            dp_op_q      <= 1'b0;
            dp_rnd_q     <= '0;
            rsp_vld_q    <= '0;
            rsp_z_q      <= '0;
            rsp_status_q <= '0;
            for (int s = 0; s <= P_LAT; s++) begin
                tag_vld_q[s] <= 1'b0;
                tag_q[s]     <= '0;
            end
        end else begin
            ptr_q        <= ptr_d;
            dp_a_q       <= dp_a_d;
            dp_b_q       <= dp_b_d;
            dp_op_q      <= dp_op_d;
            dp_rnd_q     <= dp_rnd_d;
            rsp_vld_q    <= rsp_vld_d;
            rsp_z_q      <= rsp_z_d;
            rsp_status_q <= rsp_status_d;
            tag_vld_q[0] <= accept;
            tag_q[0]     <= gnt_idx;
            for (int s = 1; s <= P_LAT; s++) begin
                tag_vld_q[s] <= tag_vld_q[s-1];
                tag_q[s]     <= tag_q[s-1];
            end
        end
    end

    always_comb begin
        inflight = 1'b0;
        for (int s = 0; s <= P_LAT; s++) begin
            inflight = inflight | tag_vld_q[s];
        end
    end

    assign bus.idle       = ~inflight & ~(|rsp_vld_q);
    assign bus.dp_a       = dp_a_q;
    assign bus.dp_b       = dp_b_q;
    assign bus.dp_op      = dp_op_q;
    assign bus.dp_rnd     = dp_rnd_q;
    assign bus.rsp_vld    = rsp_vld_q;
    assign bus.rsp_z      = rsp_z_q;
    assign bus.rsp_status = rsp_status_q;

endmodule

// File: tb/tb_fp_addsub_sched.sv
// Directed bench for fp_addsub_sched with a two-stage stand-in datapath (P_LAT = 2).
// The stand-in returns known fp sums for the listed vectors and integer add/sub otherwise.
module tb_fp_addsub_sched;
    localparam int W = 16;
    localparam int N = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    fp_addsub_sched_if #(.P_WORD(W), .P_NREQ(N)) bus ();

    fp_addsub_sched #(
        .P_EXP(5), .P_FRAC(10), .P_BIAS(15), .P_NREQ(N), .P_LAT(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    logic [W-1:0] ea [N];
    logic [W-1:0] eb [N];
    logic         eop [N];
    logic [2:0]   ernd [N];

    function automatic logic [W-1:0] fz(input logic [W-1:0] a, input logic [W-1:0] b, input logic op);
        if (a == 16'h3C00 && b == 16'h4000 && !op) return 16'h4200;
        if (a == 16'h4400 && b == 16'h3C00 && op)  return 16'h4200;
        return op ? (a - b) : (a + b);
    endfunction

    function automatic logic [7:0] fs(input logic [W-1:0] b, input logic op, input logic [2:0] rnd);
        return {rnd, op, b[15:12]};
    endfunction

    logic [W-1:0] zp0, zp1;
    logic [7:0]   sp0, sp1;
    always @(posedge clk) begin
        zp0 <= fz(bus.dp_a, bus.dp_b, bus.dp_op);
        sp0 <= fs(bus.dp_b, bus.dp_op, bus.dp_rnd);
        zp1 <= zp0;
        sp1 <= sp0;
    end
    assign bus.dp_z      = zp1;
    assign bus.dp_status = sp1;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic op, input logic [2:0] rnd);
        bus.req_a[i*W +: W]   = a;
        bus.req_b[i*W +: W]   = b;
        bus.req_op[i]         = op;
        bus.req_rnd[i*3 +: 3] = rnd;
        ea[i] = a; eb[i] = b; eop[i] = op; ernd[i] = rnd;
    endtask

    task automatic test_reset;
        rst = 1'b1; bus.cfg_en = 1'b1; bus.req_vld = 4'b1111;
        step; step;
        @(negedge clk);
        total++; if (bus.req_rdy !== 4'b0000) begin bad++; $display("FAIL reset_rdy_gate: got %b want 0000", bus.req_rdy); end
        step;
        rst = 1'b0; bus.req_vld = 4'b0000;
        @(negedge clk);
        total++; if (bus.req_rdy !== 4'b0000) begin bad++; $display("FAIL reset_rdy: got %b want 0000", bus.req_rdy); end
        total++; if (bus.rsp_vld !== 4'b0000) begin bad++; $display("FAIL reset_rsp_vld: got %b want 0000", bus.rsp_vld); end
        total++; if (bus.dp_a !== 16'h0 || bus.dp_b !== 16'h0) begin bad++; $display("FAIL reset_dp_ab: got %h/%h want 0000/0000", bus.dp_a, bus.dp_b); end
        total++; if (bus.dp_op !== 1'b0 || bus.dp_rnd !== 3'd0) begin bad++; $display("FAIL reset_dp_oprnd: got %b/%0d want 0/0", bus.dp_op, bus.dp_rnd); end
        total++; if (bus.rsp_z !== 16'h0 || bus.rsp_status !== 8'h0) begin bad++; $display("FAIL reset_rsp_data: got %h/%h want 0000/00", bus.rsp_z, bus.rsp_status); end
        total++; if (bus.idle !== 1'b1) begin bad++; $display("FAIL reset_idle: got %b want 1", bus.idle); end
        step;
    endtask

    task automatic test_single;
        set_req(2, 16'h3C00, 16'h4000, 1'b0, 3'd0);
        bus.req_vld = 4'b0100;
        @(negedge clk);
        total++; if (bus.req_rdy !== 4'b0100) begin bad++; $display("FAIL single_rdy: got %b want 0100", bus.req_rdy); end
        step;
        bus.req_vld = 4'b0000;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k == 1) begin
                total++; if (bus.dp_a !== 16'h3C00 || bus.dp_b !== 16'h4000) begin bad++; $display("FAIL single_dp_ab: got %h/%h want 3c00/4000", bus.dp_a, bus.dp_b); end
                total++; if (bus.idle !== 1'b0) begin bad++; $display("FAIL single_busy: got %b want 0", bus.idle); end
            end
            total++; if (bus.rsp_vld !== ((k == 4) ? 4'b0100 : 4'b0000)) begin bad++; $display("FAIL single_rsp_vld k=%0d: got %b", k, bus.rsp_vld); end
            if (k == 4) begin
                $display("rsp single req=2 z=%h st=%h", bus.rsp_z, bus.rsp_status);
                total++; if (bus.rsp_z !== 16'h4200) begin bad++; $display("FAIL single_z: got %h want 4200", bus.rsp_z); end
                total++; if (bus.rsp_status !== 8'h04) begin bad++; $display("FAIL single_status: got %h want 04", bus.rsp_status); end
            end
            if (k == 5) begin
                total++; if (bus.idle !== 1'b1) begin bad++; $display("FAIL single_idle: got %b want 1", bus.idle); end
                total++; if (bus.rsp_z !== 16'h4200) begin bad++; $display("FAIL single_z_hold: got %h want 4200", bus.rsp_z); end
            end
            step;
        end
    endtask

    task automatic test_back_to_back;
        logic [W-1:0] a;
        for (int c = 0; c <= 8; c++) begin
            if (c < 4) begin
                a = 16'h2000 + W'(c);
                set_req(1, a, 16'h0011, 1'b0, 3'd1);
                bus.req_vld = 4'b0010;
            end else begin
                bus.req_vld = 4'b0000;
            end
            @(negedge clk);
            total++; if (bus.req_rdy !== ((c < 4) ? 4'b0010 : 4'b0000)) begin bad++; $display("FAIL b2b_rdy c=%0d: got %b", c, bus.req_rdy); end
            total++; if (bus.rsp_vld !== ((c >= 4 && c < 8) ? 4'b0010 : 4'b0000)) begin bad++; $display("FAIL b2b_rsp_vld c=%0d: got %b", c, bus.rsp_vld); end
            if (c >= 4 && c < 8) begin
                $display("rsp b2b req=1 z=%h", bus.rsp_z);
                total++; if (bus.rsp_z !== 16'h2011 + W'(c - 4)) begin bad++; $display("FAIL b2b_z c=%0d: got %h want %h", c, bus.rsp_z, 16'h2011 + W'(c - 4)); end
                total++; if (bus.rsp_status !== 8'h20) begin bad++; $display("FAIL b2b_status c=%0d: got %h want 20", c, bus.rsp_status); end
            end
            if (c == 8) begin
                total++; if (bus.idle !== 1'b1) begin bad++; $display("FAIL b2b_idle: got %b want 1", bus.idle); end
            end
            step;
        end
    endtask

    task automatic test_contention;
        logic [N-1:0] exp_vld;
        int g;
        rst = 1'b1; step; rst = 1'b0;
        for (int i = 0; i < N; i++) begin
            set_req(i, 16'h1000 + W'(i * 16'h0123), 16'h0200 + W'(i), i[0], 3'(i));
        end
        for (int c = 0; c <= 12; c++) begin
            bus.req_vld = (c < 8) ? 4'b1111 : 4'b0000;
            @(negedge clk);
            total++; if (bus.req_rdy !== ((c < 8) ? (4'b0001 << (c % 4)) : 4'b0000)) begin bad++; $display("FAIL cont_rdy c=%0d: got %b", c, bus.req_rdy); end
            if (c >= 4 && c < 12) begin g = (c - 4) % 4; exp_vld = 4'b0001 << g; end
            else begin g = 0; exp_vld = 4'b0000; end
            total++; if (bus.rsp_vld !== exp_vld) begin bad++; $display("FAIL cont_rsp_vld c=%0d: got %b want %b", c, bus.rsp_vld, exp_vld); end
            if (exp_vld != 4'b0000) begin
                $display("rsp cont req=%0d z=%h st=%h", g, bus.rsp_z, bus.rsp_status);
                total++; if (bus.rsp_z !== fz(ea[g], eb[g], eop[g])) begin bad++; $display("FAIL cont_z c=%0d: got %h want %h", c, bus.rsp_z, fz(ea[g], eb[g], eop[g])); end
                total++; if (bus.rsp_status !== fs(eb[g], eop[g], ernd[g])) begin bad++; $display("FAIL cont_status c=%0d: got %h want %h", c, bus.rsp_status, fs(eb[g], eop[g], ernd[g])); end
            end
            step;
        end
        @(negedge clk);
        total++; if (bus.idle !== 1'b1) begin bad++; $display("FAIL cont_idle: got %b want 1", bus.idle); end
        step;
    endtask

    task automatic test_sparse;
        int gl [5] = '{1, 3, 1, 3, 1};
        for (int c = 0; c <= 9; c++) begin
            if (c == 0) bus.req_vld = 4'b0010;
            else if (c <= 4) bus.req_vld = 4'b1010;
            else bus.req_vld = 4'b0000;
            @(negedge clk);
            total++; if (bus.req_rdy !== ((c <= 4) ? (4'b0001 << gl[c]) : 4'b0000)) begin bad++; $display("FAIL sparse_rdy c=%0d: got %b", c, bus.req_rdy); end
            total++; if (bus.rsp_vld !== ((c >= 4 && c <= 8) ? (4'b0001 << gl[c-4]) : 4'b0000)) begin bad++; $display("FAIL sparse_rsp_vld c=%0d: got %b", c, bus.rsp_vld); end
            if (c == 9) begin
                total++; if (bus.idle !== 1'b1) begin bad++; $display("FAIL sparse_idle: got %b want 1", bus.idle); end
            end
            step;
        end
    endtask

    task automatic test_subtract;
        set_req(0, 16'h4400, 16'h3C00, 1'b1, 3'd2);
        for (int c = 0; c <= 5; c++) begin
            bus.req_vld = (c == 0) ? 4'b0001 : 4'b0000;
            @(negedge clk);
            if (c == 0) begin
                total++; if (bus.req_rdy !== 4'b0001) begin bad++; $display("FAIL sub_rdy: got %b want 0001", bus.req_rdy); end
            end
            if (c == 1) begin
                total++; if (bus.dp_op !== 1'b1 || bus.dp_rnd !== 3'd2) begin bad++; $display("FAIL sub_dp_oprnd: got %b/%0d want 1/2", bus.dp_op, bus.dp_rnd); end
            end
            total++; if (bus.rsp_vld !== ((c == 4) ? 4'b0001 : 4'b0000)) begin bad++; $display("FAIL sub_rsp_vld c=%0d: got %b", c, bus.rsp_vld); end
            if (c == 4) begin
                $display("rsp sub req=0 z=%h st=%h", bus.rsp_z, bus.rsp_status);
                total++; if (bus.rsp_z !== 16'h4200) begin bad++; $display("FAIL sub_z: got %h want 4200", bus.rsp_z); end
                total++; if (bus.rsp_status !== 8'h53) begin bad++; $display("FAIL sub_status: got %h want 53", bus.rsp_status); end
            end
            step;
        end
    endtask

    task automatic test_cfg_en;
        logic [N-1:0] er;
        logic [N-1:0] ev;
        for (int c = 0; c <= 13; c++) begin
            bus.cfg_en  = (c < 2 || c >= 8) ? 1'b1 : 1'b0;
            bus.req_vld = (c <= 8) ? 4'b1111 : 4'b0000;
            case (c)
                0: er = 4'b0010;
                1: er = 4'b0100;
                8: er = 4'b1000;
                default: er = 4'b0000;
            endcase
            case (c)
                4: ev = 4'b0010;
                5: ev = 4'b0100;
                12: ev = 4'b1000;
                default: ev = 4'b0000;
            endcase
            @(negedge clk);
            total++; if (bus.req_rdy !== er) begin bad++; $display("FAIL cfg_rdy c=%0d: got %b want %b", c, bus.req_rdy, er); end
            total++; if (bus.rsp_vld !== ev) begin bad++; $display("FAIL cfg_rsp_vld c=%0d: got %b want %b", c, bus.rsp_vld, ev); end
            if (c == 5) begin
                total++; if (bus.idle !== 1'b0) begin bad++; $display("FAIL cfg_busy: got %b want 0", bus.idle); end
            end
            if (c == 6 || c == 7) begin
                total++; if (bus.idle !== 1'b1) begin bad++; $display("FAIL cfg_idle c=%0d: got %b want 1", c, bus.idle); end
            end
            step;
        end
    endtask

    task automatic test_reset_midflight;
        for (int c = 0; c <= 9; c++) begin
            rst         = (c == 3) ? 1'b1 : 1'b0;
            bus.req_vld = (c <= 3 || c == 9) ? 4'b1111 : 4'b0000;
            @(negedge clk);
            if (c <= 2) begin
                total++; if (bus.req_rdy !== (4'b0001 << c)) begin bad++; $display("FAIL mid_rdy c=%0d: got %b", c, bus.req_rdy); end
            end
            if (c == 3) begin
                total++; if (bus.req_rdy !== 4'b0000) begin bad++; $display("FAIL mid_rst_rdy: got %b want 0000", bus.req_rdy); end
            end
            if (c >= 4 && c <= 8) begin
                total++; if (bus.rsp_vld !== 4'b0000) begin bad++; $display("FAIL mid_rsp_vld c=%0d: got %b want 0000", c, bus.rsp_vld); end
                total++; if (bus.idle !== 1'b1) begin bad++; $display("FAIL mid_idle c=%0d: got %b want 1", c, bus.idle); end
            end
            if (c == 4) begin
                total++; if (bus.dp_a !== 16'h0 || bus.dp_b !== 16'h0) begin bad++; $display("FAIL mid_dp_ab: got %h/%h want 0000/0000", bus.dp_a, bus.dp_b); end
                total++; if (bus.rsp_z !== 16'h0 || bus.rsp_status !== 8'h0) begin bad++; $display("FAIL mid_rsp_data: got %h/%h want 0000/00", bus.rsp_z, bus.rsp_status); end
            end
            if (c == 9) begin
                total++; if (bus.req_rdy !== 4'b0001) begin bad++; $display("FAIL mid_first_gnt: got %b want 0001", bus.req_rdy); end
            end
            step;
        end
        bus.req_vld = 4'b0000;
        step; step; step; step; step;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.cfg_en  = 1'b1;
        bus.req_vld = '0;
        bus.req_a   = '0;
        bus.req_b   = '0;
        bus.req_op  = '0;
        bus.req_rnd = '0;
        for (int i = 0; i < N; i++) begin
            ea[i] = '0; eb[i] = '0; eop[i] = 1'b0; ernd[i] = '0;
        end
        #1;
        test_reset();
        test_single();
        test_back_to_back();
        test_contention();
        test_sparse();
        test_subtract();
        test_cfg_en();
        test_reset_midflight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
